// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding load/store bridge from the MEM stage to a word-wide ack-based memory port.
// Optional MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
`default_nettype none

module data_mem_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [1:0]  Size_i,
   input  logic        ExtOp_i,
   input  logic [31:0] ALUdata_i,
   input  logic [31:0] Write_data_i,
   output logic        stall_o,
   output logic [31:0] Read_data_o,
   output logic        misalign_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        word_q, word_d;
   logic        half_q, half_d;
   logic        ext_q, ext_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;

   logic        is_half, is_word, access, trap, start;
   logic [1:0]  off;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_ext;

   assign is_half = (Size_i == 2'b01);
   assign is_word = Size_i[1];
   assign access  = MemRead_i | MemWrite_i;

`ifdef MISALIGN_TRAP_EN
   logic misal;
   assign misal = (is_half & ALUdata_i[0]) | (is_word & (|ALUdata_i[1:0]));
   assign trap  = rst_i & (state_q == IDLE) & access & misal;
`else
   assign trap  = 1'b0;
`endif

   assign start = rst_i & (state_q == IDLE) & access & ~trap;

   // Lane offset is rounded down to natural alignment; with the trap enabled only aligned accesses reach here.
   always_comb begin
      off   = ALUdata_i[1:0];
      be    = 4'b0001 << ALUdata_i[1:0];
      wdata = {4{Write_data_i[7:0]}};
      if (is_word) begin
         off   = 2'b00;
         be    = 4'b1111;
         wdata = Write_data_i;
      end else if (is_half) begin
         off   = {ALUdata_i[1], 1'b0};
         be    = ALUdata_i[1] ? 4'b1100 : 4'b0011;
         wdata = {2{Write_data_i[15:0]}};
      end
   end

   always_comb begin
      case (off_q)
         2'd0:    lane_b = mem_rdata_i[7:0];
         2'd1:    lane_b = mem_rdata_i[15:8];
         2'd2:    lane_b = mem_rdata_i[23:16];
         default: lane_b = mem_rdata_i[31:24];
      endcase
      lane_h = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      if (word_q)
         load_ext = mem_rdata_i;
      else if (half_q)
         load_ext = {{16{ext_q & lane_h[15]}}, lane_h};
      else
         load_ext = {{24{ext_q & lane_b[7]}}, lane_b};
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      word_d  = word_q;
      half_d  = half_q;
      ext_d   = ext_q;
      off_d   = off_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = REQ;
               addr_d  = ALUdata_i[31:2];
               be_d    = be;
               wdata_d = wdata;
               we_d    = MemWrite_i;
               word_d  = is_word;
               half_d  = is_half;
               ext_d   = ExtOp_i;
               off_d   = off;
            end
         end
         REQ: begin
            if (mem_ack_i) begin
               state_d = DONE;
               if (!we_q)
                  rdata_d = load_ext;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         word_q  <= 1'b0;
         half_q  <= 1'b0;
         ext_q   <= 1'b0;
         off_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         word_q  <= word_d;
         half_q  <= half_d;
         ext_q   <= ext_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
      end
   end

   assign stall_o     = start | (state_q == REQ);
   assign misalign_o  = trap;
   assign mem_req_o   = (state_q == REQ);
   assign mem_we_o    = we_q;
   assign mem_addr_o  = {addr_q, 2'b00};
   assign mem_be_o    = be_q;
   assign mem_wdata_o = wdata_q;
   assign Read_data_o = rdata_q;

endmodule

`default_nettype wire

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset:
- clk_i  in  1  rising-edge clock
- rst_i  in  1  asynchronous active-low reset
REQ-002 The block SHALL have these pipeline-side ports:
- MemRead_i  in  1  load request
- MemWrite_i  in  1  store request
- Size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- ExtOp_i  in  1  1 = sign-extend loads, 0 = zero-extend
- ALUdata_i  in  32  byte address
- Write_data_i  in  32  store data, right-aligned
- stall_o  out  1  freeze upstream stages
- Read_data_o  out  32  extended load data, feeds the MEM_WB Read_data_i port
- misalign_o  out  1  misaligned-access pulse
REQ-003 The block SHALL have these memory-side ports:
- mem_req_o  out  1  request valid
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word address, bits [1:0] = 00
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated store data
- mem_ack_i  in  1  completion, one cycle
- mem_rdata_i  in  32  read word, valid with ack

Function
REQ-004 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-005 In IDLE with MemRead_i or MemWrite_i high, the FSM SHALL go to REQ and register the address, byte enables, write data and direction. stall_o SHALL be asserted combinationally in that same cycle.
REQ-006 In REQ, mem_req_o SHALL be 1, all request fields SHALL be held stable, and stall_o SHALL be 1.
REQ-007 The FSM SHALL remain in REQ until mem_ack_i is sampled high. It SHALL then go to DONE, and on a load it SHALL capture the extended data into Read_data_o on that edge.
REQ-008 In DONE, stall_o SHALL be 0 and the pipeline inputs SHALL be ignored, so the same op is not reissued. DONE SHALL always go to IDLE.
REQ-009 An access SHALL occupy at least 3 cycles (IDLE, REQ, DONE); each cycle of mem_ack_i delay SHALL add one REQ cycle.
REQ-010 When MemRead_i and MemWrite_i are both high, the block SHALL perform a write only.
REQ-011 Byte lanes SHALL be little-endian, with a = ALUdata_i[1:0]:
- byte: be = 1 << a
- half: be = 0011 if a[1] = 0, else 1100
- word: be = 1111
REQ-012 mem_wdata_o SHALL replicate the low byte or halfword of Write_data_i into every lane.
REQ-013 Loads SHALL select the addressed lane and extend it to 32 bits: sign-extend when ExtOp_i = 1, zero-extend otherwise.
REQ-014 Read_data_o SHALL hold its value until the next load completes; stores SHALL NOT alter it.
REQ-015 mem_ack_i SHALL be ignored outside REQ.

Reset
REQ-016 While rst_i = 0, all outputs SHALL be 0 and the FSM SHALL be in IDLE, immediately and regardless of clk_i.
REQ-017 A reset during REQ SHALL drop mem_req_o at once and abandon the access. An ack arriving after reset release SHALL be ignored.

Configuration
REQ-018 The macro MISALIGN_TRAP_EN SHALL control misalignment handling. A misaligned access is a half with a[0] = 1, or a word with a != 00.
- Defined: a misaligned access in IDLE SHALL issue no request, SHALL NOT assert stall_o, SHALL leave Read_data_o unchanged, and SHALL pulse misalign_o for one cycle; the FSM SHALL stay in IDLE.
- Undefined: misalign_o SHALL be tied 0, and misaligned low address bits SHALL be cleared to natural alignment before lane selection.

Verification
REQ-019 Word load: address 0x100, ack in the first REQ cycle, rdata 0xDEADBEEF -> mem_addr_o = 0x100, be = 1111, Read_data_o = 0xDEADBEEF, stall high for exactly 2 cycles.
REQ-020 Byte load: address 0x103, ExtOp_i = 1, rdata 0x80xxxxxx -> be = 1000, Read_data_o = 0xFFFFFF80; the same access with ExtOp_i = 0 -> 0x00000080.
REQ-021 Half store: address 0x22, Write_data_i = 0x1234ABCD, ack delayed 4 cycles -> be = 1100, wdata = 0xABCDABCD, fields stable, stall high for 6 cycles.
REQ-022 Reset: rst_i low during REQ -> mem_req_o = 0 in the same cycle; an ack after release -> no state change, Read_data_o = 0.
REQ-023 Word load at 0x102 -> with MISALIGN_TRAP_EN: one-cycle misalign_o, no mem_req_o, no stall; without it: access to 0x100 with be = 1111.
